// File: rtl/opsel_pkg.sv
// opsel_pkg: shared types and constants for the ALU op-select sequencer.
//   NUM_OPS / OPCODE_W : channel count of the one-hot op mux and opcode width.
//   opcode_t, sel_t     : opcode and one-hot select bus types.
//   state_t             : sequencer FSM states.
package opsel_pkg;

    localparam int unsigned NUM_OPS  = 16;
    localparam int unsigned OPCODE_W = 4;

    typedef logic [OPCODE_W-1:0] opcode_t;
    typedef logic [NUM_OPS-1:0]  sel_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        ERR  = 2'd2
    } state_t;

endpackage

// File: rtl/opsel_onehot_dec.sv
// opsel_onehot_dec: combinational opcode to one-hot select decoder.
//   i_opcode : operation number 0..NUM_OPS-1.
//   o_select : one-hot select, bit i_opcode set.
module opsel_onehot_dec
    import opsel_pkg::*;
(
    input  opcode_t i_opcode,
    output sel_t    o_select
);

    assign o_select = sel_t'(1) << i_opcode;

endmodule

// File: rtl/opsel_sequencer.sv
// opsel_sequencer: accepts an opcode over valid/ready and drives the one-hot select bus of the
// ALU op mux for one cycle, or MULTI_CYCLES cycles for ops flagged in MULTI_MASK. Select is
// all-zero whenever no op is active.
// Optional build macro OPSEL_ILLEGAL_TRAP_EN: opcodes flagged in ILLEGAL_MASK are trapped in a
// one-cycle ERR state that pulses o_err instead of executing. Without it o_err is tied low.
// Ports:
//   i_clk       : clock, rising edge.
//   i_rst_n     : synchronous active-low reset.
//   i_op_valid  : opcode request valid.
//   i_opcode    : opcode 0..15.
//   o_op_ready  : high in IDLE; request accepted on i_op_valid && o_op_ready.
//   o_select    : one-hot select, zero when idle.
//   o_sel_valid : select is driving an active op.
//   o_done      : pulse in the last select cycle of an op.
//   o_err       : pulse for a trapped illegal opcode.
module opsel_sequencer
    import opsel_pkg::*;
#(
    parameter int unsigned MULTI_CYCLES = 4,
    parameter logic [15:0] MULTI_MASK   = 16'hC000,
    parameter logic [15:0] ILLEGAL_MASK = 16'h0100
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_op_valid,
    input  logic [3:0]  i_opcode,
    output logic        o_op_ready,
    output logic [15:0] o_select,
    output logic        o_sel_valid,
    output logic        o_done,
    output logic        o_err
);

    localparam int unsigned CntW = $clog2(MULTI_CYCLES + 1);
    localparam logic [CntW-1:0] CntMulti = CntW'(MULTI_CYCLES - 1);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);

    state_t          r_state;
    logic [CntW-1:0] r_cnt;
    opcode_t         r_op;
    logic            r_sel_valid;
    logic            r_done;
    sel_t            w_dec_sel;
    logic [CntW-1:0] w_first_cnt;

    // Remaining select cycles after the first one.
    assign w_first_cnt = MULTI_MASK[i_opcode] ? CntMulti : '0;

`ifdef OPSEL_ILLEGAL_TRAP_EN
    logic r_err;
    logic w_trap;
    assign w_trap = ILLEGAL_MASK[i_opcode];
    assign o_err  = r_err;
`else
    logic w_unused_illegal;
    assign w_unused_illegal = ^ILLEGAL_MASK;
    assign o_err = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_op        <= '0;
            r_sel_valid <= 1'b0;
            r_done      <= 1'b0;
`ifdef OPSEL_ILLEGAL_TRAP_EN
            r_err       <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (i_op_valid) begin
                        r_op <= i_opcode;
`ifdef OPSEL_ILLEGAL_TRAP_EN
                        if (w_trap) begin
                            r_state <= ERR;
                            r_err   <= 1'b1;
                        end else begin
                            r_state     <= EXEC;
                            r_sel_valid <= 1'b1;
                            r_cnt       <= w_first_cnt;
                            r_done      <= (w_first_cnt == '0);
                        end
`else
                        r_state     <= EXEC;
                        r_sel_valid <= 1'b1;
                        r_cnt       <= w_first_cnt;
                        r_done      <= (w_first_cnt == '0);
`endif
                    end
                end
                EXEC: begin
                    if (r_cnt != '0) begin
                        r_cnt  <= r_cnt - CntOne;
                        // Next cycle is the last one when the count reaches zero.
                        r_done <= (r_cnt == CntOne);
                    end else begin
                        r_state     <= IDLE;
                        r_sel_valid <= 1'b0;
                        r_done      <= 1'b0;
                    end
                end
`ifdef OPSEL_ILLEGAL_TRAP_EN
                ERR: begin
                    r_state <= IDLE;
                    r_err   <= 1'b0;
                end
`endif
                default: begin
                    r_state     <= IDLE;
                    r_sel_valid <= 1'b0;
                    r_done      <= 1'b0;
                end
            endcase
        end
    end

    opsel_onehot_dec u_dec (
        .i_opcode (r_op),
        .o_select (w_dec_sel)
    );

    // Gated by the registered valid so the bus is zero outside EXEC.
    assign o_select    = r_sel_valid ? w_dec_sel : '0;
    assign o_sel_valid = r_sel_valid;
    assign o_done      = r_done;
    assign o_op_ready  = (r_state == IDLE);

endmodule

// File: tb/tb_opsel_sequencer.sv
// tb_opsel_sequencer: directed self-checking bench for opsel_sequencer.
// Observed vector is {op_ready, sel_valid, done, err, select[15:0]}.
module tb_opsel_sequencer;

    localparam int unsigned MC    = 4;
    localparam logic [15:0] MMASK = 16'hC000;
    localparam logic [15:0] IMASK = 16'h0100;

    logic        clk;
    logic        rst_n;
    logic        op_valid;
    logic [3:0]  opcode;
    logic        op_ready;
    logic [15:0] select;
    logic        sel_valid;
    logic        done;
    logic        err;
    logic [19:0] obs;
    logic [19:0] exp_v;

    int n_tests;
    int n_fail;

    opsel_sequencer #(
        .MULTI_CYCLES (MC),
        .MULTI_MASK   (MMASK),
        .ILLEGAL_MASK (IMASK)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_op_valid  (op_valid),
        .i_opcode    (opcode),
        .o_op_ready  (op_ready),
        .o_select    (select),
        .o_sel_valid (sel_valid),
        .o_done      (done),
        .o_err       (err)
    );

    assign obs = {op_ready, sel_valid, done, err, select};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past one rising edge; outputs are sampled and inputs driven 1 time unit later.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n    = 1'b0;
        op_valid = 1'b1;
        opcode   = 4'd3;
        for (int i = 0; i < 2; i++) begin
            tick();
            exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: got %h expected %h", i, obs, exp_v);
            end
        end
        rst_n    = 1'b1;
        op_valid = 1'b0;
        tick();
        exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL reset_release: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_single;
        op_valid = 1'b1;
        opcode   = 4'd5;
        tick();
        op_valid = 1'b0;
        exp_v = {1'b0, 1'b1, 1'b1, 1'b0, 16'h0020};
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL single_exec: got %h expected %h", obs, exp_v);
        end
        tick();
        exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL single_idle: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_multi;
        op_valid = 1'b1;
        opcode   = 4'd15;
        tick();
        op_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            opcode = 4'(c + 1);  // must not disturb the running op
            exp_v = {1'b0, 1'b1, (c == 3), 1'b0, 16'h8000};
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL multi_cycle[%0d]: got %h expected %h", c, obs, exp_v);
            end
            tick();
        end
        exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL multi_idle: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_sweep;
        logic [15:0] exp_sel;
        int          n;
        for (int op = 0; op < 16; op++) begin
`ifdef OPSEL_ILLEGAL_TRAP_EN
            if (IMASK[op]) continue;
`endif
            exp_sel  = 16'h0001 << op;
            n        = MMASK[op] ? MC : 1;
            op_valid = 1'b1;
            opcode   = op[3:0];
            tick();
            op_valid = 1'b0;
            for (int c = 0; c < n; c++) begin
                exp_v = {1'b0, 1'b1, (c == n - 1), 1'b0, exp_sel};
                n_tests++;
                if (obs !== exp_v) begin
                    n_fail++;
                    $display("FAIL sweep op%0d cyc%0d: got %h expected %h", op, c, obs, exp_v);
                end
                tick();
            end
            exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL sweep_idle op%0d: got %h expected %h", op, obs, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] seq_sel [4];
        logic        seq_rdy [4];
        seq_sel[0] = 16'h0004; seq_rdy[0] = 1'b0;
        seq_sel[1] = 16'h0000; seq_rdy[1] = 1'b1;
        seq_sel[2] = 16'h0080; seq_rdy[2] = 1'b0;
        seq_sel[3] = 16'h0000; seq_rdy[3] = 1'b1;
        op_valid = 1'b1;
        opcode   = 4'd2;
        tick();
        opcode = 4'd7;  // held while op_ready is low
        for (int i = 0; i < 4; i++) begin
            exp_v = {seq_rdy[i], (seq_sel[i] != 16'h0), (seq_sel[i] != 16'h0), 1'b0, seq_sel[i]};
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL b2b[%0d]: got %h expected %h", i, obs, exp_v);
            end
            if (i == 1) begin
                tick();
                op_valid = 1'b0;
            end else begin
                tick();
            end
        end
        exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL b2b_no_dup: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_reset_mid_op;
        op_valid = 1'b1;
        opcode   = 4'd14;
        tick();
        op_valid = 1'b0;
        exp_v = {1'b0, 1'b1, 1'b0, 1'b0, 16'h4000};
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL midrst_exec: got %h expected %h", obs, exp_v);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL midrst_abort: got %h expected %h", obs, exp_v);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL midrst_idle[%0d]: got %h expected %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_illegal;
        op_valid = 1'b1;
        opcode   = 4'd8;
        tick();
        op_valid = 1'b0;
`ifdef OPSEL_ILLEGAL_TRAP_EN
        exp_v = {1'b0, 1'b0, 1'b0, 1'b1, 16'h0000};
`else
        exp_v = {1'b0, 1'b1, 1'b1, 1'b0, 16'h0100};
`endif
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL illegal_op: got %h expected %h", obs, exp_v);
        end
        tick();
        exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL illegal_after: got %h expected %h", obs, exp_v);
        end
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        op_valid = 1'b0;
        opcode   = 4'd0;
        test_reset();
        test_single();
        test_multi();
        test_sweep();
        test_back_to_back();
        test_reset_mid_op();
        test_illegal();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
